// File: rtl/acc_core_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : acc_core_pkg
//  Description : Shared opcode encodings, FSM state type and decode helper
//                for the acc_core_p accumulator core.
//  Revision    : 1.0 - initial release
// ============================================================================
package acc_core_pkg;

  // Instruction opcodes (5 bits); any value not listed executes as NOP.
  localparam logic [4:0] OP_NOP  = 5'h00;
  localparam logic [4:0] OP_LDI  = 5'h01;
  localparam logic [4:0] OP_ADD  = 5'h02;
  localparam logic [4:0] OP_SUB  = 5'h03;
  localparam logic [4:0] OP_AND  = 5'h04;
  localparam logic [4:0] OP_OR   = 5'h05;
  localparam logic [4:0] OP_XOR  = 5'h06;
  localparam logic [4:0] OP_NOT  = 5'h07;
  localparam logic [4:0] OP_SHL  = 5'h08;
  localparam logic [4:0] OP_SHR  = 5'h09;
  localparam logic [4:0] OP_INC  = 5'h0A;
  localparam logic [4:0] OP_DEC  = 5'h0B;
  localparam logic [4:0] OP_CMP  = 5'h0C;
  localparam logic [4:0] OP_JMP  = 5'h0D;
  localparam logic [4:0] OP_JZ   = 5'h0E;
  localparam logic [4:0] OP_JNZ  = 5'h0F;
  localparam logic [4:0] OP_JC   = 5'h10;
  localparam logic [4:0] OP_JNC  = 5'h11;
  localparam logic [4:0] OP_CALL = 5'h12;
  localparam logic [4:0] OP_RET  = 5'h13;
  localparam logic [4:0] OP_ADC  = 5'h14;
  localparam logic [4:0] OP_HLT  = 5'h1F;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  // True for opcodes that go through the ALU and update the flags.
  function automatic logic is_alu_op(input logic [4:0] op);
    return ((op >= OP_LDI) && (op <= OP_CMP)) || (op == OP_ADC);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_gen.sv
`default_nettype none
// ============================================================================
//  Module      : alu_gen
//  Description : Combinational width-generic ALU for acc_core_p.
//  Ports       : acc, operand   - accumulator and instruction operand
//                opcode         - 5-bit instruction opcode
//                carry_in       - current carry flag (ADC, held otherwise)
//                result         - ALU result (difference for CMP)
//                zero           - result == 0
//                carry_out      - new carry/borrow flag
//                writes_acc     - result should be written to the accumulator
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_gen
  import acc_core_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] acc,
  input  logic [DATA_W-1:0] operand,
  input  logic [4:0]        opcode,
  input  logic              carry_in,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              carry_out,
  output logic              writes_acc
);

  // One extra bit holds carry-out / borrow of the add/subtract paths.
  logic [DATA_W:0] wide;

  always_comb begin
    wide       = '0;
    result     = acc;
    carry_out  = carry_in;
    writes_acc = 1'b0;
    case (opcode)
      OP_LDI: begin
        result     = operand;
        writes_acc = 1'b1;
      end
      OP_ADD: begin
        wide       = {1'b0, acc} + {1'b0, operand};
        result     = wide[DATA_W-1:0];
        carry_out  = wide[DATA_W];
        writes_acc = 1'b1;
      end
      OP_SUB, OP_CMP: begin
        // Top bit of the extended difference is set exactly when acc < operand.
        wide       = {1'b0, acc} - {1'b0, operand};
        result     = wide[DATA_W-1:0];
        carry_out  = wide[DATA_W];
        writes_acc = (opcode == OP_SUB);
      end
      OP_AND: begin
        result     = acc & operand;
        carry_out  = 1'b0;
        writes_acc = 1'b1;
      end
      OP_OR: begin
        result     = acc | operand;
        carry_out  = 1'b0;
        writes_acc = 1'b1;
      end
      OP_XOR: begin
        result     = acc ^ operand;
        carry_out  = 1'b0;
        writes_acc = 1'b1;
      end
      OP_NOT: begin
        result     = ~acc;
        carry_out  = 1'b0;
        writes_acc = 1'b1;
      end
      OP_SHL: begin
        result     = {acc[DATA_W-2:0], 1'b0};
        carry_out  = acc[DATA_W-1];
        writes_acc = 1'b1;
      end
      OP_SHR: begin
        result     = {1'b0, acc[DATA_W-1:1]};
        carry_out  = acc[0];
        writes_acc = 1'b1;
      end
      OP_INC: begin
        wide       = {1'b0, acc} + (DATA_W+1)'(1);
        result     = wide[DATA_W-1:0];
        carry_out  = wide[DATA_W];
        writes_acc = 1'b1;
      end
      OP_DEC: begin
        wide       = {1'b0, acc} - (DATA_W+1)'(1);
        result     = wide[DATA_W-1:0];
        carry_out  = wide[DATA_W];
        writes_acc = 1'b1;
      end
      OP_ADC: begin
        wide       = {1'b0, acc} + {1'b0, operand} + {{DATA_W{1'b0}}, carry_in};
        result     = wide[DATA_W-1:0];
        carry_out  = wide[DATA_W];
        writes_acc = 1'b1;
      end
      default: ;
    endcase
    zero = (result == '0);
  end

endmodule
`default_nettype wire

// File: rtl/acc_core_p.sv
`default_nettype none
// ============================================================================
//  Module      : acc_core_p
//  Description : Parametrised accumulator core with req/ack instruction fetch,
//                carry flag, return-address stack and HALT state.
//  Ports       : clk, rst            - clock, synchronous active-high reset
//                i_step              - execute one instruction (IDLE only)
//                imem_req/addr       - registered fetch request, address = pc
//                imem_ack/opcode/data- fetch response
//                pc, acc, z_flag, c_flag - architectural state
//                busy, halted        - FSM status
//                stack_err           - sticky stack overflow/underflow
//  Revision    : 1.0 - initial release
// ============================================================================
module acc_core_p
  import acc_core_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_step,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [4:0]        imem_opcode,
  input  logic [DATA_W-1:0] imem_data,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] acc,
  output logic              z_flag,
  output logic              c_flag,
  output logic              busy,
  output logic              halted,
  output logic              stack_err
);

  // sp counts used entries (0..STACK_DEPTH); IDX_W addresses the entries.
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  state_t            state, state_nxt;
  logic              req_q;
  logic [4:0]        op_q;
  logic [DATA_W-1:0] data_q;
  logic [SP_W-1:0]   sp;
  logic [SP_W-1:0]   sp_dec;
  logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];

  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] jump_target;
  logic              stack_full, stack_empty, exec_halt;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero, alu_carry, alu_writes;

  alu_gen #(.DATA_W(DATA_W)) u_alu (
    .acc        (acc),
    .operand    (data_q),
    .opcode     (op_q),
    .carry_in   (c_flag),
    .result     (alu_result),
    .zero       (alu_zero),
    .carry_out  (alu_carry),
    .writes_acc (alu_writes)
  );

  generate
    if (DATA_W >= ADDR_W) begin : g_tgt_trunc
      assign jump_target = data_q[ADDR_W-1:0];
    end else begin : g_tgt_zext
      assign jump_target = {{(ADDR_W-DATA_W){1'b0}}, data_q};
    end
  endgenerate

  assign pc_inc      = pc + ADDR_W'(1);
  assign sp_dec      = sp - SP_W'(1);
  assign stack_full  = (sp == SP_W'(STACK_DEPTH));
  assign stack_empty = (sp == '0);
  assign exec_halt   = (op_q == OP_HLT) ||
                       ((op_q == OP_CALL) && stack_full) ||
                       ((op_q == OP_RET)  && stack_empty);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; i_step is only honoured in IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (i_step)   state_nxt = ST_FETCH;
      ST_FETCH: if (imem_ack) state_nxt = ST_EXEC;
      ST_EXEC:  state_nxt = exec_halt ? ST_HALT : ST_IDLE;
      ST_HALT:  state_nxt = ST_HALT;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Fetch handshake and architectural state.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q     <= 1'b0;
      op_q      <= OP_NOP;
      data_q    <= '0;
      pc        <= '0;
      acc       <= '0;
      z_flag    <= 1'b0;
      c_flag    <= 1'b0;
      sp        <= '0;
      stack_err <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (i_step) req_q <= 1'b1;
        ST_FETCH: begin
          if (imem_ack) begin
            req_q  <= 1'b0;
            op_q   <= imem_opcode;
            data_q <= imem_data;
          end
        end
        ST_EXEC: begin
          pc <= pc_inc;
          if (is_alu_op(op_q)) begin
            if (alu_writes) acc <= alu_result;
            z_flag <= alu_zero;
            if (op_q != OP_LDI) c_flag <= alu_carry;
          end
          // Branch conditions read the flags as they stood before this op.
          case (op_q)
            OP_JMP: pc <= jump_target;
            OP_JZ:  if (z_flag)  pc <= jump_target;
            OP_JNZ: if (!z_flag) pc <= jump_target;
            OP_JC:  if (c_flag)  pc <= jump_target;
            OP_JNC: if (!c_flag) pc <= jump_target;
            OP_CALL: begin
              if (stack_full) begin
                pc        <= pc;
                stack_err <= 1'b1;
              end else begin
                sp <= sp + SP_W'(1);
                pc <= jump_target;
              end
            end
            OP_RET: begin
              if (stack_empty) begin
                pc        <= pc;
                stack_err <= 1'b1;
              end else begin
                sp <= sp_dec;
                pc <= stack_mem[sp_dec[IDX_W-1:0]];
              end
            end
            OP_HLT:  pc <= pc;
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  // Stack contents need no reset: sp alone defines which entries are valid.
  always_ff @(posedge clk) begin
    if ((state == ST_EXEC) && (op_q == OP_CALL) && !stack_full)
      stack_mem[sp[IDX_W-1:0]] <= pc_inc;
  end

  assign imem_req  = req_q;
  assign imem_addr = pc;
  assign busy      = (state != ST_IDLE);
  assign halted    = (state == ST_HALT);

endmodule
`default_nettype wire

// File: doc/acc_core_p.md
Name: acc_core_p

Overview:
- Parametrised next-generation accumulator core: width-generic datapath, carry flag, call/return stack, HALT state.
- Fetches each instruction (5-bit opcode plus one DATA_W operand) over a req/ack instruction-memory handshake instead of having it presented directly.
- Sits between the step/debug controller (i_step) and the instruction ROM/RAM wrapper.

Parameters:
- DATA_W, 8, accumulator/operand width (>=4)
- ADDR_W, 8, program counter and instruction address width
- STACK_DEPTH, 4, return-address stack entries (>=1)

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- i_step  in  1  request execution of one instruction
- imem_req  out  1  fetch request, held until ack
- imem_addr  out  ADDR_W  fetch address (= pc)
- imem_ack  in  1  fetch data valid this cycle
- imem_opcode  in  5  fetched opcode
- imem_data  in  DATA_W  fetched operand
- pc  out  ADDR_W  program counter
- acc  out  DATA_W  accumulator
- z_flag  out  1  zero flag
- c_flag  out  1  carry/borrow flag
- busy  out  1  state != IDLE
- halted  out  1  core in HALT
- stack_err  out  1  sticky stack overflow/underflow

Behaviour:
- Reset (rst sampled high at clk edge): pc=0, acc=0, z_flag=0, c_flag=0, stack pointer=0, state=IDLE, imem_req=0, halted=0, stack_err=0. Applies in any state; aborts an outstanding fetch; a late imem_ack is ignored.
- FSM states and transitions:
  - IDLE: i_step=1 -> FETCH.
  - FETCH: imem_req=1, imem_addr=pc. Edge with imem_ack=1 latches opcode and operand -> EXEC.
  - EXEC: one cycle; architectural update at the end edge -> IDLE, or HALT per rules below.
  - HALT: exits only via rst.
- Minimum step latency: 3 cycles (i_step, FETCH with same-cycle ack, EXEC).
- i_step outside IDLE is ignored, not queued.
- imem_req is registered; a zero-latency ack is legal.
- Default pc <= pc+1, wrapping from 2^ADDR_W-1 to 0.
- Opcodes (other values are NOP). All arithmetic is modulo 2^DATA_W; d = operand.
  - 00 NOP.
  - 01 LDI: acc=d.
  - 02 ADD: acc+d; C=carry-out.
  - 03 SUB: acc-d; C=borrow.
  - 04 AND, 05 OR, 06 XOR: acc op d; C=0.
  - 07 NOT: ~acc; C=0.
  - 08 SHL: C=acc msb.
  - 09 SHR (logical): C=acc lsb.
  - 0A INC: C=carry-out.
  - 0B DEC: C=borrow.
  - 0C CMP: flags from acc-d; acc unchanged.
  - 14 ADC: acc+d+C; C=carry-out.
  - Ops 01-0C and 14 update Z=(result==0). LDI updates Z only; C unchanged.
  - 0D JMP: pc = d[ADDR_W-1:0] (zero-extended if DATA_W<ADDR_W).
  - 0E JZ, 0F JNZ, 10 JC, 11 JNC: conditional jump using flag values held before this instruction.
  - 12 CALL: push pc+1 (wrapped), pc=d.
  - 13 RET: pop into pc.
  - 1F HLT: pc unchanged, enter HALT.
- Stack boundaries:
  - CALL with STACK_DEPTH entries used: no push, pc unchanged, stack_err=1, enter HALT.
  - RET on empty stack: same.
  - Flags and acc are never modified by branch or stack ops.
- halted=1 in HALT; busy=1 in FETCH, EXEC and HALT.

Decomposition:
- Shared package acc_core_pkg holds:
  - opcode localparams (OP_NOP .. OP_HLT)
  - FSM state encoding (ST_IDLE, ST_FETCH, ST_EXEC, ST_HALT)
- One combinational sub-module alu_gen #(DATA_W): inputs acc, operand, opcode, carry_in; outputs result, zero, carry_out, writes_acc.
- Stack is an internal register array in acc_core_p.

Test Plan:
- Reset then step LDI 0xFF, ADD 0x01 with 1-cycle-delayed ack -> acc=0x00, Z=1, C=1, pc=2; each step takes 4 cycles; busy high throughout.
- LDI 0x05, CMP 0x05, JZ 0x40 -> acc=0x05, Z=1, pc=0x40; then JNC 0x10 -> pc=0x10 (C=0, no borrow).
- CALL 0x20 at pc=0x03, then RET at 0x20 -> pc=0x04; five nested CALLs with STACK_DEPTH=4 -> stack_err=1, halted=1, pc holds fifth CALL's address; further i_step ignored.
- rst asserted mid-FETCH with ack arriving the next cycle -> imem_req=0 after the reset edge, pc=0, acc=0, state IDLE, ack ignored.
- pc=0xFF executing NOP -> pc=0x00; i_step pulsed during EXEC -> no extra fetch.
- DATA_W=16, ADDR_W=10: LDI 0x8001, SHL -> acc=0x0002, C=1; ADC 0x0000 -> acc=0x0003, C=0.
